// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(4x4,3x3) PE: default widths, the AT output-transform
// matrix and the PE state encoding.
package winograd_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAccW  = 24;
  localparam int unsigned DefOutW  = 16;
  localparam int unsigned DefMaxCh = 128;
  localparam int unsigned DefIdxW  = 9;

  // Every non-zero entry is +/-2^n, so the transform needs no multipliers.
  localparam int WinoAt [4][6] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  typedef enum logic [1:0] {
    StAcc,
    StRow,
    StCol,
    StOut
  } wino_state_e;

endpackage

// File: rtl/wino_xform_1d.sv
// 6-point to 4-point Winograd output transform y = AT * x, built from constant shifts and
// add/subtract terms derived from the AT coefficient table.
module wino_xform_1d
  import winograd_pkg::*;
#(
  parameter int unsigned IN_W  = DefAccW + 4,
  parameter int unsigned RES_W = DefAccW + 8
) (
  input  logic [5:0][IN_W-1:0]  x,
  output logic [3:0][RES_W-1:0] y
);

  logic signed [RES_W-1:0] ext [6];
  logic signed [RES_W-1:0] sum;

  always_comb begin
    sum = '0;
    y   = '0;
    for (int k = 0; k < 6; k++) begin
      ext[k] = RES_W'($signed(x[k]));
    end
    for (int r = 0; r < 4; r++) begin
      sum = '0;
      for (int k = 0; k < 6; k++) begin
        if (WinoAt[r][k] > 0) begin
          sum = sum + (ext[k] <<< $clog2(WinoAt[r][k]));
        end else if (WinoAt[r][k] < 0) begin
          sum = sum - (ext[k] <<< $clog2(-WinoAt[r][k]));
        end
      end
      y[r] = sum;
    end
  end

endmodule

// File: rtl/wino_pe_acc.sv
// Winograd F(4x4,3x3) PE: per-channel element-wise MAC into M, then Y = AT*M*A on shared 1-D
// transforms. Define WINO_PE_SAT_EN to clamp Y to the OUT_W signed range instead of wrapping.
module wino_pe_acc
  import winograd_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned MAX_CH = DefMaxCh,
  parameter int unsigned IDX_W  = DefIdxW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic                         in_mode,
  input  logic [36*DATA_W-1:0]         in_tile,
  input  logic [36*DATA_W-1:0]         w_tile,
  input  logic [IDX_W-1:0]             in_row_idx,
  input  logic [IDX_W-1:0]             in_col_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [16*OUT_W-1:0]          out_tile,
  output logic [IDX_W-1:0]             out_row_idx,
  output logic [IDX_W-1:0]             out_col_idx,
  output logic [$clog2(MAX_CH+1)-1:0]  out_ch_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_CH + 1);
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned TW    = ACC_W + 4;
  localparam int unsigned YW    = ACC_W + 8;

  wino_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q [36];
  logic signed [TW-1:0]    t_q   [24];
  logic [16*OUT_W-1:0]     y_q, y_d;
  logic [CNT_W-1:0]        cnt_q, ch_cnt_q;
  logic [IDX_W-1:0]        row_q, col_q;
  logic                    mode_q;

  logic signed [PW-1:0]    prod [36];
  logic [5:0][TW-1:0]      xf_in  [6];
  logic [3:0][YW-1:0]      xf_out [6];
  logic                    accept, last_beat;

  function automatic logic [OUT_W-1:0] reduce(input logic signed [YW-1:0] v);
`ifdef WINO_PE_SAT_EN
    logic signed [YW-1:0] sat_hi;
    logic signed [YW-1:0] sat_lo;
    sat_hi = {{(YW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    sat_lo = ~sat_hi;
    if (v > sat_hi) begin
      return sat_hi[OUT_W-1:0];
    end else if (v < sat_lo) begin
      return sat_lo[OUT_W-1:0];
    end
    return v[OUT_W-1:0];
`else
    return OUT_W'(v);
`endif
  endfunction

  assign in_ready    = (state_q == StAcc);
  assign out_valid   = (state_q == StOut);
  assign accept      = in_valid && in_ready;
  assign last_beat   = in_last || (cnt_q == CNT_W'(MAX_CH - 1));
  assign out_tile    = y_q;
  assign out_row_idx = row_q;
  assign out_col_idx = col_q;
  assign out_ch_cnt  = ch_cnt_q;

  always_comb begin
    for (int i = 0; i < 36; i++) begin
      prod[i] = PW'($signed(in_tile[i*DATA_W +: DATA_W])) *
                PW'($signed(w_tile[i*DATA_W +: DATA_W]));
    end
  end

  // ROW feeds column j of M into transform j; COL reuses transforms 0..3 on rows of T.
  always_comb begin
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 6; k++) begin
        if (state_q == StCol && j < 4) begin
          xf_in[j][k] = t_q[j*6+k];
        end else begin
          xf_in[j][k] = TW'(acc_q[k*6+j]);
        end
      end
    end
  end

  for (genvar j = 0; j < 6; j++) begin : g_xf
    wino_xform_1d #(
      .IN_W  (TW),
      .RES_W (YW)
    ) u_xf (
      .x (xf_in[j]),
      .y (xf_out[j])
    );
  end

  always_comb begin
    y_d = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mode_q) begin
          y_d[(r*4+c)*OUT_W +: OUT_W] = reduce(YW'(acc_q[r*6+c]));
        end else begin
          y_d[(r*4+c)*OUT_W +: OUT_W] = reduce($signed(xf_out[r][c]));
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StAcc:   if (accept && last_beat) state_d = StRow;
      StRow:   state_d = StCol;
      StCol:   state_d = StOut;
      StOut:   if (out_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StAcc;
      cnt_q    <= '0;
      ch_cnt_q <= '0;
      mode_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      y_q      <= '0;
      for (int i = 0; i < 36; i++) acc_q[i] <= '0;
      for (int i = 0; i < 24; i++) t_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StAcc: begin
          if (accept) begin
            for (int i = 0; i < 36; i++) acc_q[i] <= acc_q[i] + ACC_W'(prod[i]);
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == '0) mode_q <= in_mode;
            if (last_beat) begin
              row_q <= in_row_idx;
              col_q <= in_col_idx;
            end
          end
        end
        StRow: begin
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 6; c++) t_q[r*6+c] <= TW'(xf_out[c][r]);
          end
        end
        StCol: begin
          y_q      <= y_d;
          ch_cnt_q <= cnt_q;
        end
        StOut: begin
          if (out_ready) begin
            for (int i = 0; i < 36; i++) acc_q[i] <= '0;
            cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wino_pe_acc.sv
// Scoreboard bench for wino_pe_acc: a matrix reference model pushes expected tiles on the last
// beat; each scenario task pops and compares when out_valid appears.
module tb_wino_pe_acc;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 24;
  localparam int unsigned OW = 16;
  localparam int unsigned MC = 4;
  localparam int unsigned IW = 9;
  localparam int unsigned CW = $clog2(MC + 1);
  localparam int unsigned VW = 36 * DW;
  localparam int unsigned YW = 16 * OW;

  localparam int AT [4][6] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic          in_mode = 1'b0;
  logic [VW-1:0] in_tile = '0;
  logic [VW-1:0] w_tile = '0;
  logic [IW-1:0] in_row_idx = '0;
  logic [IW-1:0] in_col_idx = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [YW-1:0] out_tile;
  logic [IW-1:0] out_row_idx;
  logic [IW-1:0] out_col_idx;
  logic [CW-1:0] out_ch_cnt;

  wino_pe_acc #(
    .DATA_W (DW),
    .ACC_W  (AW),
    .OUT_W  (OW),
    .MAX_CH (MC),
    .IDX_W  (IW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_mode     (in_mode),
    .in_tile     (in_tile),
    .w_tile      (w_tile),
    .in_row_idx  (in_row_idx),
    .in_col_idx  (in_col_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tile    (out_tile),
    .out_row_idx (out_row_idx),
    .out_col_idx (out_col_idx),
    .out_ch_cnt  (out_ch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [YW-1:0] tile;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint m_acc [36];
  int     m_cnt = 0;
  logic   m_mode = 1'b0;

  function automatic logic [VW-1:0] fill(input int val);
    logic [VW-1:0] t;
    for (int i = 0; i < 36; i++) t[i*DW +: DW] = DW'(val);
    return t;
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] t;
    for (int i = 0; i < 36; i++) t[i*DW +: DW] = DW'(i);
    return t;
  endfunction

  function automatic logic [OW-1:0] ref_red(input longint v);
    longint hi;
    logic [63:0] b;
    hi = (longint'(1) <<< (OW - 1)) - 1;
`ifdef WINO_PE_SAT_EN
    if (v > hi) v = hi;
    else if (v < -hi - 1) v = -hi - 1;
`endif
    b = v;
    return b[OW-1:0];
  endfunction

  function automatic logic [OW-1:0] el(input logic [YW-1:0] t, input int idx);
    return t[idx*OW +: OW];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 36; i++) m_acc[i] = 0;
    m_cnt = 0;
  endtask

  task automatic model_finish(input logic [IW-1:0] row, input logic [IW-1:0] col);
    exp_t   e;
    longint t [4][6];
    longint s;
    e.tile = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        t[r][c] = 0;
        for (int k = 0; k < 6; k++) t[r][c] += AT[r][k] * m_acc[k*6+c];
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = 0;
        if (m_mode) s = m_acc[r*6+c];
        else for (int k = 0; k < 6; k++) s += t[r][k] * AT[c][k];
        e.tile[(r*4+c)*OW +: OW] = ref_red(s);
      end
    end
    e.row = row;
    e.col = col;
    e.cnt = CW'(m_cnt);
    sb.push_back(e);
    model_clear();
  endtask

  task automatic drive_beat(input logic [VW-1:0] v, input logic [VW-1:0] u, input logic last,
                            input logic mode, input logic [IW-1:0] row, input logic [IW-1:0] col);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_tile = v; w_tile = u; in_last = last; in_mode = mode;
    in_row_idx = row; in_col_idx = col;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
    end else begin
      @(posedge clk);
      if (m_cnt == 0) m_mode = mode;
      for (int i = 0; i < 36; i++) begin
        m_acc[i] += longint'($signed(v[i*DW +: DW])) * longint'($signed(u[i*DW +: DW]));
      end
      m_cnt++;
      if (last || m_cnt == MC) model_finish(row, col);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (out_valid === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: valid/ready=%b%b required 01", out_valid, in_ready);
    end
    checks++;
    if (out_tile !== '0 || out_row_idx !== '0 || out_col_idx !== '0 || out_ch_cnt !== '0) begin
      errors++;
      $display("FAIL reset_out: tile=%h row=%0d col=%0d cnt=%0d required all 0",
               out_tile, out_row_idx, out_col_idx, out_ch_cnt);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_ones();
    exp_t e;
    bit   ok;
    drive_beat(fill(1), fill(1), 1'b1, 1'b0, 9'd1, 9'd2);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_e0: got %b required 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_e1: got %b required 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_e2: got %b required 1", out_valid); end
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if (out_tile !== e.tile) begin
        errors++;
        $display("FAIL ones_tile: got %h required %h", out_tile, e.tile);
      end
      checks++;
      if ({el(out_tile, 0), el(out_tile, 1), el(out_tile, 2), el(out_tile, 10), el(out_tile, 15),
           out_ch_cnt} !== {16'd25, 16'd0, 16'd50, 16'd100, 16'd1, 3'd1}) begin
        errors++;
        $display("FAIL ones_spot: Y00=%0d Y01=%0d Y02=%0d Y22=%0d Y33=%0d cnt=%0d required 25 0 50 100 1 1",
                 el(out_tile, 0), el(out_tile, 1), el(out_tile, 2), el(out_tile, 10),
                 el(out_tile, 15), out_ch_cnt);
      end
    end
    release_out();
  endtask

  task automatic test_multi();
    exp_t e;
    bit   ok;
    drive_beat(fill(1), fill(2), 1'b0, 1'b0, 9'd100, 9'd100);
    drive_beat(fill(1), fill(2), 1'b0, 1'b0, 9'd101, 9'd101);
    drive_beat(fill(1), fill(2), 1'b1, 1'b0, 9'd4, 9'd5);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if ({out_tile, out_row_idx, out_col_idx, out_ch_cnt} !== e) begin
        errors++;
        $display("FAIL multi_out: tile=%h row=%0d col=%0d cnt=%0d required %h %0d %0d %0d",
                 out_tile, out_row_idx, out_col_idx, out_ch_cnt, e.tile, e.row, e.col, e.cnt);
      end
      checks++;
      if ({el(out_tile, 0), el(out_tile, 2), el(out_tile, 15), out_ch_cnt}
          !== {16'd150, 16'd300, 16'd6, 3'd3}) begin
        errors++;
        $display("FAIL multi_spot: Y00=%0d Y02=%0d Y33=%0d cnt=%0d required 150 300 6 3",
                 el(out_tile, 0), el(out_tile, 2), el(out_tile, 15), out_ch_cnt);
      end
    end
    release_out();
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    bit   bad;
    drive_beat(fill(2), fill(3), 1'b1, 1'b0, 9'd11, 9'd12);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_valid = 1'b1; in_tile = fill(7); w_tile = fill(7); in_last = 1'b1;
        #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
            {out_tile, out_row_idx, out_col_idx, out_ch_cnt} !== e) bad = 1'b1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL hold_stable: valid=%b ready=%b tile=%h required 1 0 %h",
                 out_valid, in_ready, out_tile, e.tile);
      end
    end
    release_out();
    drive_beat(fill(1), fill(-1), 1'b1, 1'b0, 9'd3, 9'd3);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if ({out_tile, out_row_idx, out_col_idx, out_ch_cnt} !== e) begin
        errors++;
        $display("FAIL after_hold: tile=%h cnt=%0d required %h %0d",
                 out_tile, out_ch_cnt, e.tile, e.cnt);
      end
    end
    release_out();
  endtask

  task automatic test_bypass();
    exp_t e;
    bit   ok;
    drive_beat(ramp(), fill(-1), 1'b1, 1'b1, 9'd7, 9'd3);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if (out_tile !== e.tile) begin
        errors++;
        $display("FAIL byp_tile: got %h required %h", out_tile, e.tile);
      end
      checks++;
      if ({el(out_tile, 5), el(out_tile, 15), out_row_idx, out_col_idx}
          !== {16'hFFF9, 16'hFFEB, 9'd7, 9'd3}) begin
        errors++;
        $display("FAIL byp_spot: Y11=%h Y33=%h row=%0d col=%0d required fff9 ffeb 7 3",
                 el(out_tile, 5), el(out_tile, 15), out_row_idx, out_col_idx);
      end
    end
    release_out();
  endtask

  task automatic test_sat();
    exp_t        e;
    bit          ok;
    logic [15:0] y00;
`ifdef WINO_PE_SAT_EN
    y00 = 16'd32767;
`else
    y00 = 16'd16384;
`endif
    drive_beat(fill(-128), fill(-128), 1'b1, 1'b0, 9'd0, 9'd1);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if (out_tile !== e.tile) begin
        errors++;
        $display("FAIL sat_tile: got %h required %h", out_tile, e.tile);
      end
      checks++;
      if (el(out_tile, 0) !== y00) begin
        errors++;
        $display("FAIL sat_y00: got %0d required %0d", el(out_tile, 0), y00);
      end
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    bit   seen;
    drive_beat(fill(5), fill(5), 1'b0, 1'b0, 9'd1, 9'd1);
    drive_beat(fill(5), fill(5), 1'b0, 1'b0, 9'd1, 9'd1);
    @(negedge clk); #2;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    drive_beat(fill(1), fill(1), 1'b1, 1'b0, 9'd2, 9'd2);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if ({el(out_tile, 0), out_ch_cnt} !== {16'd25, 3'd1} || out_tile !== e.tile) begin
        errors++;
        $display("FAIL rst_group: Y00=%0d cnt=%0d required 25 1", el(out_tile, 0), out_ch_cnt);
      end
    end
    release_out();
    drive_beat(fill(3), fill(3), 1'b1, 1'b0, 9'd2, 9'd2);
    #2;
    reset = 1'b1;
    void'(sb.pop_back());
    model_clear();
    #5;
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_xform: out_valid rose after reset, required 0");
    end
  endtask

  task automatic test_max_ch();
    exp_t e;
    bit   ok;
    for (int b = 0; b < 4; b++) drive_beat(fill(1), fill(1), 1'b0, 1'b0, 9'd9, 9'd10);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      checks++;
      if ({out_tile, out_row_idx, out_col_idx, out_ch_cnt} !== e ||
          {el(out_tile, 0), out_ch_cnt} !== {16'd100, 3'd4}) begin
        errors++;
        $display("FAIL maxch: Y00=%0d cnt=%0d required 100 4", el(out_tile, 0), out_ch_cnt);
      end
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    exp_t   e;
    bit     ok;
    longint t0;
    longint t1;
    t0 = 0;
    t1 = 0;
    out_ready = 1'b1;
    fork
      begin
        drive_beat(ramp(), fill(1), 1'b0, 1'b1, 9'd1, 9'd1);
        t0 = $time;
        drive_beat(ramp(), fill(1), 1'b1, 1'b0, 9'd6, 9'd8);
        drive_beat(fill(1), fill(1), 1'b1, 1'b0, 9'd2, 9'd2);
        t1 = $time;
      end
      begin
        wait_out(ok);
        if (ok) begin
          e = sb.pop_front();
          checks++;
          if ({out_tile, out_row_idx, out_col_idx, out_ch_cnt} !== e ||
              el(out_tile, 15) !== 16'd42) begin
            errors++;
            $display("FAIL b2b_a: tile=%h row=%0d col=%0d cnt=%0d required %h 6 8 2",
                     out_tile, out_row_idx, out_col_idx, out_ch_cnt, e.tile);
          end
        end
        @(negedge clk);
        wait_out(ok);
        if (ok) begin
          e = sb.pop_front();
          checks++;
          if ({out_tile, out_ch_cnt} !== {e.tile, e.cnt}) begin
            errors++;
            $display("FAIL b2b_b: tile=%h cnt=%0d required %h %0d",
                     out_tile, out_ch_cnt, e.tile, e.cnt);
          end
        end
      end
    join
    out_ready = 1'b0;
    checks++;
    if (t1 - t0 != 50) begin
      errors++;
      $display("FAIL b2b_rate: group period %0d ns required 50", t1 - t0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_multi();
    test_backpressure();
    test_bypass();
    test_sat();
    test_reset_mid();
    test_max_ch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
